// File: rtl/fc_pkg.sv
// Shared constants for the fully-connected layer feeder: sequencer state codes,
// default operand width and a width helper that never returns less than one bit.
package fc_pkg;

   localparam int FC_IN_DATA_WIDTH = 8;

   typedef logic [2:0] fc_state_t;

   localparam fc_state_t ST_IDLE   = 3'd0;
   localparam fc_state_t ST_CLEAR  = 3'd1;
   localparam fc_state_t ST_FEED   = 3'd2;
   localparam fc_state_t ST_DRAIN  = 3'd3;
   localparam fc_state_t ST_RESULT = 3'd4;
   localparam fc_state_t ST_WAIT   = 3'd5;
   localparam fc_state_t ST_DONE   = 3'd6;

   function automatic int clog2_min1(input int value);
      return (value > 1) ? $clog2(value) : 1;
   endfunction

endpackage

// File: rtl/fc_feeder_if.sv
// Memory read ports plus the operand stream towards the MAC core, seen from the feeder
// (master) and from the memories/core (slave).
interface fc_feeder_if #(
   parameter int IN_DATA_WIDTH = 8,
   parameter int NA_W          = 4,
   parameter int WA_W          = 7,
   parameter int BA_W          = 3
);
   logic                     o_node_ce;
   logic [NA_W-1:0]          o_node_addr;
   logic [IN_DATA_WIDTH-1:0] i_node_rdata;
   logic                     o_wegt_ce;
   logic [WA_W-1:0]          o_wegt_addr;
   logic [IN_DATA_WIDTH-1:0] i_wegt_rdata;
   logic [BA_W-1:0]          o_bias_addr;
   logic [IN_DATA_WIDTH-1:0] i_bias_rdata;
   logic                     o_run;
   logic                     o_valid;
   logic [IN_DATA_WIDTH-1:0] o_node;
   logic [IN_DATA_WIDTH-1:0] o_wegt;
   logic [IN_DATA_WIDTH-1:0] o_bias;
   logic                     o_acc_done;
   logic [BA_W-1:0]          o_neuron_idx;

   modport master (
      output o_node_ce, o_node_addr, o_wegt_ce, o_wegt_addr, o_bias_addr,
      output o_run, o_valid, o_node, o_wegt, o_bias, o_acc_done, o_neuron_idx,
      input  i_node_rdata, i_wegt_rdata, i_bias_rdata
   );

   modport slave (
      input  o_node_ce, o_node_addr, o_wegt_ce, o_wegt_addr, o_bias_addr,
      input  o_run, o_valid, o_node, o_wegt, o_bias, o_acc_done, o_neuron_idx,
      output i_node_rdata, i_wegt_rdata, i_bias_rdata
   );

endinterface

// File: rtl/fc_feed_counter.sv
// Nested element (k) / neuron (j) counters with a weight address that simply counts
// up alongside k, so j*NUM_IN+k never needs a multiplier.
module fc_feed_counter #(
   parameter int NUM_IN  = 16,
   parameter int NUM_OUT = 8,
   parameter int NA_W    = 4,
   parameter int WA_W    = 7,
   parameter int BA_W    = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            clear_k,
   input  logic            step,
   input  logic            next_j,
   output logic [NA_W-1:0] k,
   output logic [WA_W-1:0] wa,
   output logic [BA_W-1:0] j,
   output logic            k_last,
   output logic            j_last
);

   localparam logic [NA_W-1:0] K_MAX  = NA_W'(NUM_IN - 1);
   localparam logic [WA_W-1:0] WA_MAX = WA_W'(NUM_IN * NUM_OUT - 1);
   localparam logic [BA_W-1:0] J_MAX  = BA_W'(NUM_OUT - 1);

   logic [NA_W-1:0] k_reg, k_next;
   logic [WA_W-1:0] wa_reg, wa_next;
   logic [BA_W-1:0] j_reg, j_next;

   assign k      = k_reg;
   assign wa     = wa_reg;
   assign j      = j_reg;
   assign k_last = (k_reg == K_MAX);
   assign j_last = (j_reg == J_MAX);

   always_comb begin
      k_next  = k_reg;
      wa_next = wa_reg;
      j_next  = j_reg;
      if (start) begin
         k_next  = '0;
         wa_next = '0;
         j_next  = '0;
      end else begin
         if (clear_k) begin
            k_next = '0;
         end else if (step) begin
            k_next = k_last ? '0 : k_reg + 1'b1;
            // Saturate on the final element so the address never wraps mid-layer.
            wa_next = (wa_reg == WA_MAX) ? wa_reg : wa_reg + 1'b1;
         end
         if (next_j && !j_last) begin
            j_next = j_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k_reg  <= '0;
         wa_reg <= '0;
         j_reg  <= '0;
      end else begin
         k_reg  <= k_next;
         wa_reg <= wa_next;
         j_reg  <= j_next;
      end
   end

endmodule

// File: rtl/fc_feeder.sv
// Sequencer feeding one neuron at a time into the MAC core: clear, stream NUM_IN
// operand pairs from 1-cycle-latency memories, flag the final result, repeat per neuron.
module fc_feeder
   import fc_pkg::*;
#(
   parameter int IN_DATA_WIDTH = FC_IN_DATA_WIDTH,
   parameter int NUM_IN        = 16,
   parameter int NUM_OUT       = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic        i_out_ready,
   output logic        o_busy,
   output logic        o_done,
   fc_feeder_if.master bus
);

   localparam int NA_W = clog2_min1(NUM_IN);
   localparam int WA_W = clog2_min1(NUM_IN * NUM_OUT);
   localparam int BA_W = clog2_min1(NUM_OUT);

   fc_state_t state_reg, state_next;

   logic            cnt_start;
   logic            cnt_clear_k;
   logic            cnt_step;
   logic            cnt_next_j;
   logic [NA_W-1:0] k_cnt;
   logic [WA_W-1:0] wa_cnt;
   logic [BA_W-1:0] j_cnt;
   logic            k_last;
   logic            j_last;

   logic            read_ce;
   logic            valid_reg;
   logic            first_reg;

   fc_feed_counter #(
      .NUM_IN  (NUM_IN),
      .NUM_OUT (NUM_OUT),
      .NA_W    (NA_W),
      .WA_W    (WA_W),
      .BA_W    (BA_W)
   ) u_counter (
      .clk     (clk),
      .reset   (reset),
      .start   (cnt_start),
      .clear_k (cnt_clear_k),
      .step    (cnt_step),
      .next_j  (cnt_next_j),
      .k       (k_cnt),
      .wa      (wa_cnt),
      .j       (j_cnt),
      .k_last  (k_last),
      .j_last  (j_last)
   );

   always_comb begin
      state_next  = state_reg;
      cnt_start   = 1'b0;
      cnt_clear_k = 1'b0;
      cnt_step    = 1'b0;
      cnt_next_j  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (i_start) begin
               state_next = ST_CLEAR;
               cnt_start  = 1'b1;
            end
         end
         ST_CLEAR: begin
            cnt_clear_k = 1'b1;
            state_next  = ST_FEED;
         end
         ST_FEED: begin
            cnt_step = 1'b1;
            if (k_last) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_next = ST_RESULT;
         end
         ST_RESULT: begin
            if (j_last) begin
               state_next = ST_DONE;
            end else if (i_out_ready) begin
               state_next = ST_CLEAR;
               cnt_next_j = 1'b1;
            end else begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_out_ready) begin
               state_next = ST_CLEAR;
               cnt_next_j = 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign read_ce = (state_reg == ST_FEED);

   // Read data arrives one cycle after the enable; the core adds bias on every valid
   // element, so bias is only let through on the k==0 element.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         valid_reg <= 1'b0;
         first_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         valid_reg <= read_ce;
         first_reg <= read_ce && (k_cnt == '0);
      end
   end

   assign o_busy           = (state_reg != ST_IDLE);
   assign o_done           = (state_reg == ST_DONE);

   assign bus.o_node_ce    = read_ce;
   assign bus.o_wegt_ce    = read_ce;
   assign bus.o_node_addr  = k_cnt;
   assign bus.o_wegt_addr  = wa_cnt;
   assign bus.o_bias_addr  = j_cnt;
   assign bus.o_run        = (state_reg == ST_CLEAR);
   assign bus.o_valid      = valid_reg;
   assign bus.o_acc_done   = (state_reg == ST_RESULT);
   assign bus.o_neuron_idx = j_cnt;

   for (genvar gi = 0; gi < IN_DATA_WIDTH; gi++) begin : g_data_gate
      assign bus.o_node[gi] = valid_reg & bus.i_node_rdata[gi];
      assign bus.o_wegt[gi] = valid_reg & bus.i_wegt_rdata[gi];
      assign bus.o_bias[gi] = first_reg & bus.i_bias_rdata[gi];
   end

endmodule
